// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register array and its scheduler.
package instr_register_pkg;

  localparam int unsigned SCHED_DEPTH   = 32;
  localparam int unsigned SCHED_PTR_W   = $clog2(SCHED_DEPTH);
  localparam int unsigned SCHED_NUM_REQ = 2;

  typedef enum logic [3:0] {ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD} opcode_t;
  typedef logic signed [31:0] operand_t;
  typedef logic signed [63:0] result_t;
  typedef logic [SCHED_PTR_W-1:0] address_t;

  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
    result_t  rslt;
  } instruction_t;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} sched_state_t;

  // Queue pointer advance with wrap at the last array slot.
  function automatic address_t ptr_inc(input address_t p);
    return (p == address_t'(SCHED_DEPTH - 1)) ? '0 : p + address_t'(1);
  endfunction

endpackage

// File: rtl/instr_reg_sched_rr_arb2.sv
// 2-way round-robin arbiter: on a tie, the requester that did not win last time is granted.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = '0;
    case (req)
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = req;
    endcase
  end

endmodule

// File: rtl/instr_reg_sched.sv
// Scheduler in front of the instruction register array: arbitrates writers, runs the queue, drains responses.
// Optional statistics counters are enabled with `define INSTR_SCHED_STATS_EN.
module instr_reg_sched
  import instr_register_pkg::*;
(
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              flush,
  input  logic [SCHED_NUM_REQ-1:0]          req_valid,
  output logic [SCHED_NUM_REQ-1:0]          req_ready,
  input  opcode_t  [SCHED_NUM_REQ-1:0]      req_opcode,
  input  operand_t [SCHED_NUM_REQ-1:0]      req_operand_a,
  input  operand_t [SCHED_NUM_REQ-1:0]      req_operand_b,
  output logic                              load_en,
  output opcode_t                           opcode,
  output operand_t                          operand_a,
  output operand_t                          operand_b,
  output address_t                          write_pointer,
  output address_t                          read_pointer,
  output logic                              reg_reset_n,
  input  instruction_t                      instruction_word,
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output instruction_t                      rsp_instr,
  output logic [SCHED_PTR_W:0]              count,
  output logic                              full,
  output logic                              empty
`ifdef INSTR_SCHED_STATS_EN
  ,
  output logic [15:0]                       wr_total,
  output logic [15:0]                       rd_total
`endif
);

  localparam int unsigned DEPTH = SCHED_DEPTH;
  localparam int unsigned PTR_W = SCHED_PTR_W;
  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(DEPTH);

  localparam logic [1:0] ST_IDLE  = 2'(IDLE);
  localparam logic [1:0] ST_RUN   = 2'(RUN);
  localparam logic [1:0] ST_FLUSH = 2'(FLUSH);

  logic [1:0]     state, state_nxt;
  address_t       wr_ptr, wr_ptr_nxt;
  address_t       rd_ptr, rd_ptr_nxt;
  logic [PTR_W:0] count_nxt;
  logic           rsp_valid_nxt;
  instruction_t   rsp_instr_nxt;
  logic           last_grant, last_grant_nxt;
  logic [1:0]     grant;
  logic           in_flush;
  logic           rd_en;

  rr_arb2 u_arb (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign in_flush      = (state == ST_FLUSH);
  assign full          = (count == DEPTH_CNT);
  assign empty         = (count == '0);
  assign reg_reset_n   = ~(reset | in_flush);
  assign req_ready     = grant & {SCHED_NUM_REQ{~full & ~in_flush & ~flush & ~reset}};
  assign load_en       = |(req_valid & req_ready);
  assign opcode        = grant[1] ? req_opcode[1]    : req_opcode[0];
  assign operand_a     = grant[1] ? req_operand_a[1] : req_operand_a[0];
  assign operand_b     = grant[1] ? req_operand_b[1] : req_operand_b[0];
  assign write_pointer = wr_ptr;
  assign read_pointer  = rd_ptr;
  // Refill the response register whenever it is free or being consumed this cycle.
  assign rd_en = (count != '0) & (~rsp_valid | rsp_ready) & ~in_flush & ~flush & ~reset;

  // Next-state: queue bookkeeping and FSM transition.
  always_comb begin
    state_nxt      = state;
    wr_ptr_nxt     = wr_ptr;
    rd_ptr_nxt     = rd_ptr;
    count_nxt      = count;
    rsp_valid_nxt  = rsp_valid;
    rsp_instr_nxt  = rsp_instr;
    last_grant_nxt = last_grant;

    if (in_flush) begin
      wr_ptr_nxt    = '0;
      rd_ptr_nxt    = '0;
      count_nxt     = '0;
      rsp_valid_nxt = 1'b0;
    end else begin
      if (load_en) begin
        wr_ptr_nxt     = ptr_inc(wr_ptr);
        last_grant_nxt = grant[1];
      end
      if (rd_en) begin
        rsp_instr_nxt = instruction_word;
        rsp_valid_nxt = 1'b1;
        rd_ptr_nxt    = ptr_inc(rd_ptr);
      end else if (rsp_ready) begin
        rsp_valid_nxt = 1'b0;
      end
      count_nxt = count + (PTR_W + 1)'(load_en) - (PTR_W + 1)'(rd_en);
    end

    if (flush) begin
      state_nxt = ST_FLUSH;
    end else if (in_flush) begin
      state_nxt = ST_IDLE;
    end else if ((count_nxt == '0) && !rsp_valid_nxt) begin
      state_nxt = ST_IDLE;
    end else begin
      state_nxt = ST_RUN;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      rsp_valid  <= 1'b0;
      rsp_instr  <= '0;
      last_grant <= 1'b1;
    end else begin
      state      <= state_nxt;
      wr_ptr     <= wr_ptr_nxt;
      rd_ptr     <= rd_ptr_nxt;
      count      <= count_nxt;
      rsp_valid  <= rsp_valid_nxt;
      rsp_instr  <= rsp_instr_nxt;
      last_grant <= last_grant_nxt;
    end
  end

`ifdef INSTR_SCHED_STATS_EN
  // Saturating traffic counters; survive flush, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_total <= '0;
      rd_total <= '0;
    end else begin
      if (load_en && (wr_total != 16'hFFFF)) wr_total <= wr_total + 16'd1;
      if (rsp_valid && rsp_ready && (rd_total != 16'hFFFF)) rd_total <= rd_total + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_reg_sched.sv
// Scoreboard bench for instr_reg_sched with a behavioural model of the register array.
module tb_instr_reg_sched;
  import instr_register_pkg::*;

  logic                  clk = 1'b0;
  logic                  reset, flush;
  logic [1:0]            req_valid, req_ready;
  opcode_t  [1:0]        req_opcode;
  operand_t [1:0]        req_operand_a, req_operand_b;
  logic                  load_en;
  opcode_t               opcode;
  operand_t              operand_a, operand_b;
  address_t              write_pointer, read_pointer;
  logic                  reg_reset_n;
  instruction_t          instruction_word;
  logic                  rsp_valid, rsp_ready;
  instruction_t          rsp_instr;
  logic [SCHED_PTR_W:0]  count;
  logic                  full, empty;
`ifdef INSTR_SCHED_STATS_EN
  logic [15:0]           wr_total, rd_total;
`endif

  int n_cmp = 0;
  int n_err = 0;
  instruction_t sb[$];
  instruction_t mem [SCHED_DEPTH];

  always #5 clk = ~clk;

  instr_reg_sched dut (
    .clk              (clk),
    .reset            (reset),
    .flush            (flush),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_opcode       (req_opcode),
    .req_operand_a    (req_operand_a),
    .req_operand_b    (req_operand_b),
    .load_en          (load_en),
    .opcode           (opcode),
    .operand_a        (operand_a),
    .operand_b        (operand_b),
    .write_pointer    (write_pointer),
    .read_pointer     (read_pointer),
    .reg_reset_n      (reg_reset_n),
    .instruction_word (instruction_word),
    .rsp_valid        (rsp_valid),
    .rsp_ready        (rsp_ready),
    .rsp_instr        (rsp_instr),
    .count            (count),
    .full             (full),
    .empty            (empty)
`ifdef INSTR_SCHED_STATS_EN
    ,
    .wr_total         (wr_total),
    .rd_total         (rd_total)
`endif
  );

  function automatic result_t calc(input opcode_t o, input operand_t a, input operand_t b);
    case (o)
      PASSA:   return result_t'(a);
      PASSB:   return result_t'(b);
      ADD:     return result_t'(a) + result_t'(b);
      SUB:     return result_t'(a) - result_t'(b);
      MULT:    return result_t'(a) * result_t'(b);
      DIV:     return (b == 0) ? '0 : result_t'(a) / result_t'(b);
      MOD:     return (b == 0) ? '0 : result_t'(a) % result_t'(b);
      default: return '0;
    endcase
  endfunction

  function automatic instruction_t mk(input opcode_t o, input operand_t a, input operand_t b);
    instruction_t r;
    r.opc  = o;
    r.op_a = a;
    r.op_b = b;
    r.rslt = calc(o, a, b);
    return r;
  endfunction

  // Register array model: cleared by reg_reset_n, written on load_en, read combinationally.
  always @(posedge clk) begin
    if (!reg_reset_n) begin
      for (int i = 0; i < SCHED_DEPTH; i++) mem[i] <= '0;
    end else if (load_en) begin
      mem[write_pointer] <= mk(opcode, operand_a, operand_b);
    end
  end
  assign instruction_word = mem[read_pointer];

  // Response monitor: every completed handshake must match the oldest expected entry.
  always @(negedge clk) begin
    if (!reset && rsp_valid && rsp_ready) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL rsp_unexpected: got %h, scoreboard empty", rsp_instr);
      end else begin
        instruction_t e;
        e = sb.pop_front();
        if (rsp_instr !== e) begin
          n_err++;
          $display("FAIL rsp_order: got %h expected %h", rsp_instr, e);
        end
      end
    end
  end

  task automatic drive_idle();
    req_valid        = 2'b00;
    req_opcode[0]    = ZERO;
    req_opcode[1]    = ZERO;
    req_operand_a[0] = 0;
    req_operand_a[1] = 0;
    req_operand_b[0] = 0;
    req_operand_b[1] = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; flush = 1'b0; rsp_ready = 1'b0;
    drive_idle();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    reset = 1'b1; req_valid = 2'b01; req_opcode[0] = ADD;
    @(negedge clk);
    n_cmp++; if (load_en !== 1'b0) begin n_err++; $display("FAIL reset_load_en: got %b expected 0", load_en); end
    n_cmp++; if (reg_reset_n !== 1'b0) begin n_err++; $display("FAIL reset_reg_reset_n: got %b expected 0", reg_reset_n); end
    @(posedge clk); #1;
    reset = 1'b0; drive_idle();
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    n_cmp++; if (rsp_instr !== '0) begin n_err++; $display("FAIL reset_rsp_instr: got %h expected 0", rsp_instr); end
    n_cmp++; if (count !== '0 || empty !== 1'b1 || full !== 1'b0) begin
      n_err++; $display("FAIL reset_occupancy: got count=%0d empty=%b full=%b expected 0/1/0", count, empty, full);
    end
    n_cmp++; if (write_pointer !== '0 || read_pointer !== '0) begin
      n_err++; $display("FAIL reset_pointers: got wp=%0d rp=%0d expected 0/0", write_pointer, read_pointer);
    end
    n_cmp++; if (reg_reset_n !== 1'b1) begin n_err++; $display("FAIL reset_release: got %b expected 1", reg_reset_n); end
  endtask

  task automatic test_basic();
    instruction_t e;
    do_reset();
    e = mk(ADD, 5, 3);
    @(posedge clk); #1;
    req_valid = 2'b01; req_opcode[0] = ADD; req_operand_a[0] = 5; req_operand_b[0] = 3; rsp_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (load_en !== 1'b1 || write_pointer !== '0) begin
      n_err++; $display("FAIL basic_write: got load_en=%b wp=%0d expected 1/0", load_en, write_pointer);
    end
    n_cmp++; if (opcode !== ADD || operand_a !== 5 || operand_b !== 3) begin
      n_err++; $display("FAIL basic_mux: got %0d/%0d/%0d expected 3/5/3", opcode, operand_a, operand_b);
    end
    sb.push_back(e);
    @(posedge clk); #1;
    drive_idle();
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 1'b0 || count !== 1 || load_en !== 1'b0) begin
      n_err++; $display("FAIL basic_latency1: got rsp_valid=%b count=%0d load_en=%b expected 0/1/0", rsp_valid, count, load_en);
    end
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_instr !== e) begin
      n_err++; $display("FAIL basic_rsp: got v=%b %h expected 1 %h", rsp_valid, rsp_instr, e);
    end
    n_cmp++; if (count !== '0) begin n_err++; $display("FAIL basic_count: got %0d expected 0", count); end
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 1'b0 || empty !== 1'b1) begin
      n_err++; $display("FAIL basic_done: got rsp_valid=%b empty=%b expected 0/1", rsp_valid, empty);
    end
  endtask

  task automatic test_arbitration();
    logic [1:0] g;
    operand_t   exp_a [4];
    do_reset();
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      req_valid = 2'b11;
      req_opcode[0] = ADD; req_operand_a[0] = 10 + k; req_operand_b[0] = 1;
      req_opcode[1] = SUB; req_operand_a[1] = 20 + k; req_operand_b[1] = 2;
      @(negedge clk);
      g = (k % 2 == 0) ? 2'b01 : 2'b10;
      n_cmp++; if (req_ready !== g || load_en !== 1'b1 || write_pointer !== address_t'(k)) begin
        n_err++; $display("FAIL arb_grant%0d: got ready=%b load=%b wp=%0d expected %b/1/%0d", k, req_ready, load_en, write_pointer, g, k);
      end
      exp_a[k] = (k % 2 == 0) ? 10 + k : 20 + k;
      sb.push_back((k % 2 == 0) ? mk(ADD, 10 + k, 1) : mk(SUB, 20 + k, 2));
    end
    @(posedge clk); #1;
    drive_idle();
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (mem[k].op_a !== exp_a[k]) begin
        n_err++; $display("FAIL arb_slot%0d: got %0d expected %0d", k, mem[k].op_a, exp_a[k]);
      end
    end
    rsp_ready = 1'b1;
    for (int t = 0; t < 100 && (sb.size() != 0 || rsp_valid); t++) @(negedge clk);
    n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL arb_drain: got %0d left expected 0", sb.size()); end
  endtask

  task automatic test_full();
    int   mcount = 0;
    logic mvalid = 1'b0;
    int   nacc   = 0;
    logic rr, ew, er;
    do_reset();
    for (int c = 0; c < 45; c++) begin
      rr = (c >= 38);
      @(posedge clk); #1;
      req_valid = 2'b01; req_opcode[0] = ADD; req_operand_a[0] = nacc; req_operand_b[0] = 1; rsp_ready = rr;
      @(negedge clk);
      ew = (mcount < SCHED_DEPTH);
      er = (mcount > 0) && (!mvalid || rr);
      n_cmp++; if (req_ready[0] !== ew || count !== (SCHED_PTR_W + 1)'(mcount) || full !== (mcount == SCHED_DEPTH)) begin
        n_err++; $display("FAIL full_c%0d: got ready=%b count=%0d full=%b expected %b/%0d/%b", c, req_ready[0], count, full, ew, mcount, mcount == SCHED_DEPTH);
      end
      if (c == 37) begin
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_instr !== mk(ADD, 0, 1)) begin
          n_err++; $display("FAIL full_hold: got v=%b %h expected slot-0 entry", rsp_valid, rsp_instr);
        end
      end
      if (ew) begin sb.push_back(mk(ADD, nacc, 1)); nacc++; end
      if (er) mvalid = 1'b1; else if (rr) mvalid = 1'b0;
      mcount = mcount + (ew ? 1 : 0) - (er ? 1 : 0);
    end
    @(posedge clk); #1;
    drive_idle(); rsp_ready = 1'b1;
    for (int t = 0; t < 200 && (sb.size() != 0 || rsp_valid); t++) @(negedge clk);
    n_cmp++; if (sb.size() != 0 || empty !== 1'b1) begin
      n_err++; $display("FAIL full_drain: got %0d left empty=%b expected 0/1", sb.size(), empty);
    end
  endtask

  task automatic test_wrap();
    opcode_t o;
    do_reset();
    for (int n = 0; n < 40; n++) begin
      o = opcode_t'(4'(3 + n % 3));
      @(posedge clk); #1;
      req_valid = 2'b01; req_opcode[0] = o; req_operand_a[0] = 100 + n; req_operand_b[0] = n; rsp_ready = 1'b1;
      @(negedge clk);
      n_cmp++; if (load_en !== 1'b1 || write_pointer !== address_t'(n % SCHED_DEPTH)) begin
        n_err++; $display("FAIL wrap_wp%0d: got load=%b wp=%0d expected 1/%0d", n, load_en, write_pointer, n % SCHED_DEPTH);
      end
      sb.push_back(mk(o, 100 + n, n));
    end
    @(posedge clk); #1;
    drive_idle();
    for (int t = 0; t < 100 && (sb.size() != 0 || rsp_valid); t++) @(negedge clk);
    n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL wrap_drain: got %0d left expected 0", sb.size()); end
    n_cmp++; if (write_pointer !== address_t'(8) || read_pointer !== address_t'(8)) begin
      n_err++; $display("FAIL wrap_ptrs: got wp=%0d rp=%0d expected 8/8", write_pointer, read_pointer);
    end
`ifdef INSTR_SCHED_STATS_EN
    n_cmp++; if (wr_total !== 16'd40 || rd_total !== 16'd40) begin
      n_err++; $display("FAIL wrap_stats: got wr=%0d rd=%0d expected 40/40", wr_total, rd_total);
    end
`endif
  endtask

  task automatic test_flush();
    do_reset();
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      req_valid = 2'b01; req_opcode[0] = MULT; req_operand_a[0] = k; req_operand_b[0] = 3;
      @(negedge clk);
    end
    @(posedge clk); #1;
    flush = 1'b1;
    @(negedge clk);
    n_cmp++; if (count !== 7 || rsp_valid !== 1'b1) begin
      n_err++; $display("FAIL flush_pre: got count=%0d rsp_valid=%b expected 7/1", count, rsp_valid);
    end
    n_cmp++; if (req_ready !== 2'b00 || load_en !== 1'b0 || reg_reset_n !== 1'b1) begin
      n_err++; $display("FAIL flush_req: got ready=%b load=%b rrn=%b expected 00/0/1", req_ready, load_en, reg_reset_n);
    end
    @(posedge clk); #1;
    flush = 1'b0; drive_idle();
    @(negedge clk);
    n_cmp++; if (reg_reset_n !== 1'b0 || req_ready !== 2'b00) begin
      n_err++; $display("FAIL flush_cycle: got rrn=%b ready=%b expected 0/00", reg_reset_n, req_ready);
    end
    @(negedge clk);
    n_cmp++; if (reg_reset_n !== 1'b1 || count !== '0 || rsp_valid !== 1'b0 || empty !== 1'b1) begin
      n_err++; $display("FAIL flush_post: got rrn=%b count=%0d v=%b empty=%b expected 1/0/0/1", reg_reset_n, count, rsp_valid, empty);
    end
    n_cmp++; if (dut.state !== 2'(IDLE) || write_pointer !== '0 || read_pointer !== '0) begin
      n_err++; $display("FAIL flush_state: got st=%0d wp=%0d rp=%0d expected 0/0/0", dut.state, write_pointer, read_pointer);
    end
    sb.delete();
  endtask

  task automatic test_reset_mid_write();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      req_valid = 2'b01; req_opcode[0] = SUB; req_operand_a[0] = k; req_operand_b[0] = 1;
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    n_cmp++; if (load_en !== 1'b0 || req_ready !== 2'b00) begin
      n_err++; $display("FAIL rstmid_write: got load=%b ready=%b expected 0/00", load_en, req_ready);
    end
    @(negedge clk);
    n_cmp++; if (count !== '0 || rsp_valid !== 1'b0 || rsp_instr !== '0 || write_pointer !== '0) begin
      n_err++; $display("FAIL rstmid_state: got count=%0d v=%b instr=%h wp=%0d expected 0/0/0/0", count, rsp_valid, rsp_instr, write_pointer);
    end
`ifdef INSTR_SCHED_STATS_EN
    n_cmp++; if (wr_total !== '0 || rd_total !== '0) begin
      n_err++; $display("FAIL rstmid_stats: got wr=%0d rd=%0d expected 0/0", wr_total, rd_total);
    end
`endif
    @(posedge clk); #1;
    reset = 1'b0; drive_idle();
    sb.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; flush = 1'b0; rsp_ready = 1'b0;
    drive_idle();
    test_reset();
    test_basic();
    test_arbitration();
    test_full();
    test_wrap();
    test_flush();
    test_reset_mid_write();
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
